// File: rtl/ps_link_pkg.sv
// ps_link_pkg: symbols and state encoding shared by both ends of the serial link
package ps_link_pkg;
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;
    typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/paralelo_serial_tx_if.sv
// paralelo_serial_tx_if: byte-side handshake plus serial lane outputs of the sender
interface paralelo_serial_tx_if;
    logic       link_en;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active_out;
    logic       idle_out;
    logic       byte_tick;
    modport master (
        output link_en, data_in, valid_in,
        input  ready_out, data_out, active_out, idle_out, byte_tick
    );
    modport slave (
        input  link_en, data_in, valid_in,
        output ready_out, data_out, active_out, idle_out, byte_tick
    );
endinterface

// File: rtl/ps_shift8.sv
// ps_shift8: 8-bit load/shift register, MSB out, with the free-running bit counter
module ps_shift8 (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] sym,
    output logic       boundary,
    output logic       data_out
);
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    assign boundary = bit_cnt == 3'd7;
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= 3'd7;
            shreg    <= 8'd0;
            data_out <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            data_out <= boundary ? sym[7] : shreg[7];
            shreg    <= boundary ? {sym[6:0], 1'b0} : {shreg[6:0], 1'b0};
        end
    end
endmodule

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: serializes handshaked bytes MSB first after a COM training phase,
// filling empty slots with IDLE symbols.
module paralelo_serial_tx #(
    parameter logic [7:0] COM_SYM    = ps_link_pkg::COM_SYM,
    parameter logic [7:0] IDLE_SYM   = ps_link_pkg::IDLE_SYM,
    parameter int         SYNC_BYTES = 4
) (
    input logic                 clk_32f,
    input logic                 reset,
    paralelo_serial_tx_if.slave lnk
);
    import ps_link_pkg::state_t;
    import ps_link_pkg::SYNC;
    import ps_link_pkg::ACTIVE;
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_BYTES - 1);
    state_t     state;
    logic [7:0] sync_cnt;
    logic [7:0] sym;
    logic       boundary;
    logic       sync_done;
    logic       idle_q;
    logic       tick_q;
    // >= so a return from ACTIVE (sync_cnt preset to 1) still works when SYNC_BYTES==1
    assign sync_done      = lnk.link_en && sync_cnt >= SYNC_LAST;
    assign lnk.ready_out  = state == ACTIVE && boundary && lnk.link_en;
    assign lnk.active_out = state == ACTIVE;
    assign lnk.idle_out   = idle_q;
    assign lnk.byte_tick  = tick_q;
    always_comb sym = (state == SYNC || !lnk.link_en) ? COM_SYM : lnk.valid_in ? lnk.data_in : IDLE_SYM;
    ps_shift8 u_shift (
        .clk_32f (clk_32f),
        .reset   (reset),
        .sym     (sym),
        .boundary(boundary),
        .data_out(lnk.data_out)
    );
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state    <= SYNC;
            sync_cnt <= 8'd0;
            idle_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= boundary;
            if (boundary) begin
                idle_q <= lnk.ready_out && !lnk.valid_in;
                if (state == SYNC) begin
                    state    <= sync_done ? ACTIVE : SYNC;
                    sync_cnt <= (!lnk.link_en || sync_done) ? 8'd0 : sync_cnt + 8'd1;
                end else if (!lnk.link_en) begin
                    state    <= SYNC;
                    sync_cnt <= 8'd1;
                end
            end
        end
    end
endmodule
